fast_readout_pipe: RTL and testbench

FAST_READOUT_PIPE -- requirements
Module: fast_readout_pipe

---
 rtl/fast_readout_pipe.sv | 118 +++++++++++
 tb/tb_fast_readout_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fast_readout_pipe.sv
// fast_readout_pipe
//   Adds two unsigned operands with an optional saturate mode. The result passes
//   through a single register stage (S1) and then into a small output FIFO that
//   the consumer drains with a valid/ready handshake. A sticky flag records
//   whether any accepted pair produced a carry.
//
// Ports
//   clk, rst      single clock; synchronous active-high reset
//   ena           design enable; low blocks input acceptance only
//   in_valid      operand pair present
//   in_ready      block can accept a pair this cycle
//   in_a, in_b    operands (WIDTH bits, unsigned)
//   sat_mode      0 = wrap, 1 = saturate (sampled with each accepted pair)
//   out_valid     FIFO head holds a result
//   out_ready     consumer takes the head this cycle
//   out_data      result at FIFO head (0 when out_valid = 0)
//   out_carry     carry flag of the head result (0 when out_valid = 0)
//   level         number of results held in the FIFO
//   ovf_sticky    a carried result has been accepted since the last clear
//   clr_sticky    clears ovf_sticky (a same-edge set wins)
module fast_readout_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     sat_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_carry,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_sticky,
    input  logic                     clr_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Returns {carry, data}. In saturate mode an overflow clamps the data to
    // all ones; without overflow the raw sum already carries a zero flag.
    function automatic logic [WIDTH:0] add_result(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sat
    );
        logic [WIDTH:0] raw;
        raw = {1'b0, a} + {1'b0, b};
        if (sat && raw[WIDTH])
            return {1'b1, {WIDTH{1'b1}}};
        return raw;
    endfunction

    logic                 s1_valid;
    logic [WIDTH:0]       s1_result;
    logic [WIDTH:0]       mem [DEPTH];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [LW:0]          occupancy;
    logic [WIDTH:0]       sum_result;
    logic                 accept;
    logic                 pop;

    // The slot held by S1 is already committed to the FIFO, so it counts
    // against free space; this keeps in_ready free of any out_ready path.
    assign occupancy  = {1'b0, level} + (LW+1)'(s1_valid);
    assign in_ready   = ena & ~rst & (occupancy < (LW+1)'(DEPTH));
    assign accept     = in_valid & in_ready;
    assign sum_result = add_result(in_a, in_b, sat_mode);

    assign out_valid  = (level != '0);
    assign pop        = out_valid & out_ready;
    assign {out_carry, out_data} = out_valid ? mem[rptr] : '0;

    // Control state: S1 valid, FIFO pointers, level, sticky flag
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (s1_valid)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({s1_valid, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (accept && sum_result[WIDTH])
                ovf_sticky <= 1'b1;
            else if (clr_sticky)
                ovf_sticky <= 1'b0;
        end
    end

    // Stage S1: register the computed result on accept
    always_ff @(posedge clk) begin
        if (accept)
            s1_result <= sum_result;
    end

    // FIFO write: S1 drains into the FIFO the edge after it fills
    always_ff @(posedge clk) begin
        if (s1_valid)
            mem[wptr] <= s1_result;
    end

endmodule

// File: tb/tb_fast_readout_pipe.sv
module tb_fast_readout_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    ena = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_a = '0;
    logic [WIDTH-1:0]        in_b = '0;
    logic                    sat_mode = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [WIDTH-1:0]        out_data;
    logic                    out_carry;
    logic [$clog2(DEPTH):0]  level;
    logic                    ovf_sticky;
    logic                    clr_sticky = 1'b0;

    fast_readout_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .sat_mode(sat_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry),
        .level(level), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: expected results in acceptance order, FIFO count,
    // whether a result sits in the register stage, and the sticky flag.
    logic [WIDTH:0] q[$];
    int             exp_level = 0;
    bit             m_s1      = 1'b0;
    bit             m_sticky  = 1'b0;

    function automatic logic [WIDTH:0] ref_sum(int a, int b, bit sat);
        int maxv;
        int raw;
        bit c;
        int d;
        maxv = (1 << WIDTH) - 1;
        raw  = a + b;
        c    = (raw > maxv);
        d    = (sat && c) ? maxv : (raw % (maxv + 1));
        return {c, WIDTH'(d)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus: verify state, drive inputs, predict.
    task automatic step(input bit v, input int a, input int b, input bit sat,
                        input bit e, input bit ordy, input bit clr, input bit r);
        bit exp_rdy;
        bit acc;
        bit pp;
        logic [WIDTH:0] res;
        @(negedge clk);
        chk("level", 64'(level), 64'(exp_level));
        chk("out_valid", 64'(out_valid), 64'(exp_level != 0));
        chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
        in_valid   = v;
        in_a       = WIDTH'(a);
        in_b       = WIDTH'(b);
        sat_mode   = sat;
        ena        = e;
        out_ready  = ordy;
        clr_sticky = clr;
        rst        = r;
        #1;
        exp_rdy = !r && e && ((exp_level + int'(m_s1)) < DEPTH);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (r) begin
            q.delete();
            exp_level = 0;
            m_s1      = 1'b0;
            m_sticky  = 1'b0;
        end else begin
            acc = v && exp_rdy;
            pp  = (exp_level != 0) && ordy;
            exp_level = exp_level + int'(m_s1) - int'(pp);
            if (acc) begin
                res = ref_sum(a, b, sat);
                q.push_back(res);
            end else begin
                res = '0;
            end
            if (acc && res[WIDTH])
                m_sticky = 1'b1;
            else if (clr)
                m_sticky = 1'b0;
            m_s1 = acc;
        end
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 0, 0, 1, ordy, 0, 0);
    endtask

    // Monitor: pops the expected queue whenever the DUT hands out a result.
    logic [WIDTH:0] held;
    bit             hold_valid = 1'b0;

    always @(negedge clk) begin
        logic [WIDTH:0] exp;
        #2;
        if (hold_valid && out_valid)
            chk("head_stable", 64'({out_carry, out_data}), 64'(held));
        if (!out_valid)
            chk("idle_zero", 64'({out_carry, out_data}), 64'(0));
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got %0h expected none", {out_carry, out_data});
            end else begin
                exp = q.pop_front();
                chk("pop_result", 64'({out_carry, out_data}), 64'(exp));
            end
        end
        hold_valid = !rst && out_valid && !out_ready;
        held       = {out_carry, out_data};
    end

    initial begin
        // reset
        step(0, 0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0, 1);
        // first accept on first edge out of reset, wrap-mode basics
        step(1, 8'h01, 8'h02, 0, 1, 1, 0, 0);
        idle(1); idle(1);
        step(1, 8'hFF, 8'h00, 0, 1, 1, 0, 0);
        step(1, 8'h00, 8'hFF, 0, 1, 1, 0, 0);
        idle(1); idle(1);
        // carry, saturate, set-beats-clear, then plain clear
        step(1, 8'hFF, 8'hFF, 0, 1, 1, 0, 0);
        step(1, 8'hFF, 8'hFF, 1, 1, 1, 0, 0);
        step(1, 8'h80, 8'h80, 0, 1, 1, 1, 0);
        idle(1);
        step(0, 0, 0, 0, 1, 1, 1, 0);
        step(1, 8'h90, 8'h20, 1, 1, 1, 0, 0);
        idle(1); idle(1);
        // backpressure: 6 offered pairs, FIFO fills to DEPTH
        for (int i = 0; i < 6; i++)
            step(1, 16 * i + 3, 7 * i, 0, 1, 0, 0, 0);
        idle(0); idle(0);
        for (int i = 0; i < 6; i++)
            idle(1);
        // back-to-back stream of 16 with a ready consumer
        for (int i = 0; i < 16; i++)
            step(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 bit'($urandom_range(0, 1)), 1, 1, 0, 0);
        idle(1); idle(1); idle(1);
        // ena low blocks acceptance while pending results drain
        step(1, 8'h11, 8'h22, 0, 1, 0, 0, 0);
        step(1, 8'h33, 8'h44, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(1, 8'h55, 8'h66, 0, 0, 1, 0, 0);
        // reset mid-operation with FIFO at 3 and S1 occupied
        step(1, 8'hF0, 8'hF0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, i + 1, i + 2, 0, 1, 0, 0, 0);
        step(1, 8'h12, 8'h34, 0, 1, 1, 0, 1);
        idle(1); idle(1);
        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) != 0), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
        for (int i = 0; i < 8; i++)
            idle(1);
        @(negedge clk);
        #3;
        chk("drained", 64'(q.size()), 64'(0));
        chk("final_level", 64'(level), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
